muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_core.sv | 61 ++++++
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the sequential HI/LO multiply/divide unit.
// MULDIV_SIGNED_EN enables signed MULT/DIV and the magnitude helper below.
package muldiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ITERS = 32;
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

   localparam logic [2:0] OP_MULTU = 3'd0;
   localparam logic [2:0] OP_DIVU  = 3'd1;
   localparam logic [2:0] OP_MULT  = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIN
   } state_e;

`ifdef MULDIV_SIGNED_EN
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
`endif

endpackage

// File: rtl/muldiv_core.sv
// Shift/accumulate datapath: radix-2 shift-add multiply and restoring divide,
// one bit per step. {hi_o,lo_o} holds product, or remainder/quotient.
module muldiv_core #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         load_mul_i,
   input  logic         load_div_i,
   input  logic         step_mul_i,
   input  logic         step_div_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] opd_q, opd_d;
   logic [W:0]   sum;
   logic [W:0]   shifted;

   always_comb begin
      hi_d    = hi_q;
      lo_d    = lo_q;
      opd_d   = opd_q;
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      shifted = {hi_q, lo_q[W-1]};
      if (load_mul_i) begin
         // lo holds the multiplier and is shifted out as product bits shift in
         hi_d  = '0;
         lo_d  = b_i;
         opd_d = a_i;
      end else if (load_div_i) begin
         hi_d  = '0;
         lo_d  = a_i;
         opd_d = b_i;
      end else if (step_mul_i) begin
         hi_d = sum[W:1];
         lo_d = {sum[0], lo_q[W-1:1]};
      end else if (step_div_i) begin
         if (shifted >= {1'b0, opd_q}) begin
            hi_d = W'(shifted - {1'b0, opd_q});
            lo_d = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_d = shifted[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MIPS-style HI/LO multiply/divide unit: FSM, counter, HI/LO, handshake.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they alias MULTU/DIVU.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             cancel,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero
);

   import muldiv_pkg::*;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, dz_q;

   logic             accept, is_mul, is_div, rt_zero;
   logic [WIDTH-1:0] opa, opb, core_hi, core_lo, res_hi, res_lo;

   assign op_ready = (state_q == S_IDLE) && !reset;
   assign busy     = (state_q != S_IDLE) && !reset;
   assign stall    = hilo_rd && busy;
   assign done     = done_q && !reset;
   assign div_zero = dz_q && !reset;
   assign hi       = hi_q;
   assign lo       = lo_q;

   assign accept  = op_valid && op_ready;
   assign is_mul  = (op == OP_MULTU) || (op == OP_MULT);
   assign is_div  = (op == OP_DIVU) || (op == OP_DIV);
   assign rt_zero = (rt == '0);

`ifdef MULDIV_SIGNED_EN
   logic              sgn_op;
   logic              neg_res_q, neg_rem_q, was_mul_q;
   logic [2*WIDTH-1:0] prod;

   assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
   assign opa    = sgn_op ? mag(rs) : rs;
   assign opb    = sgn_op ? mag(rt) : rt;

   always_ff @(posedge clk) begin
      if (accept) begin
         neg_res_q <= sgn_op && (rs[WIDTH-1] ^ rt[WIDTH-1]);
         neg_rem_q <= sgn_op && rs[WIDTH-1];
         was_mul_q <= is_mul;
      end
   end

   // The datapath works on magnitudes; signs are restored only when committing
   always_comb begin
      prod   = {core_hi, core_lo};
      res_hi = core_hi;
      res_lo = core_lo;
      if (was_mul_q) begin
         if (neg_res_q) prod = -prod;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else begin
         if (neg_res_q) res_lo = -core_lo;
         if (neg_rem_q) res_hi = -core_hi;
      end
   end
`else
   assign opa    = rs;
   assign opb    = rt;
   assign res_hi = core_hi;
   assign res_lo = core_lo;
`endif

   muldiv_core #(
      .W (WIDTH)
   ) u_core (
      .clk        (clk),
      .load_mul_i (accept && is_mul),
      .load_div_i (accept && is_div && !rt_zero),
      .step_mul_i (state_q == S_MUL),
      .step_div_i (state_q == S_DIV),
      .a_i        (opa),
      .b_i        (opb),
      .hi_o       (core_hi),
      .lo_o       (core_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cnt_q <= '0;
                  if (is_mul) begin
                     state_q <= S_MUL;
                  end else if (is_div && rt_zero) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                     dz_q    <= 1'b1;
                  end else if (is_div) begin
                     state_q <= S_DIV;
                  end else if (op == OP_MTHI) begin
                     hi_q <= rs;
                  end else if (op == OP_MTLO) begin
                     lo_q <= rs;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (cancel) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_ITER) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               if (!dz_q) begin
                  hi_q <= res_hi;
                  lo_q <= res_lo;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
